// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EX-stage forwarding/hazard unit: mux select codes and shadow tag entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fwd_hazard_unit_pkg;

    // The width of the dest field in the shadow entry is set here. The unit's REG_ADDR_W parameter must match it.
    localparam int FHU_REG_ADDR_W = 3;

    // Operand-mux select codes seen by the EX stage.
    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    // One in-flight instruction tag in the shadow pipeline.
    typedef struct packed {
        logic                      valid;
        logic [FHU_REG_ADDR_W-1:0] dest;
        logic                      wb_en;
        logic                      mem_read;
    } shadow_ent_t;

    localparam shadow_ent_t SHADOW_BUBBLE = '0;

    // An entry produces r when it will write r. R0 is hardwired to zero and is never produced.
    function automatic logic produces(shadow_ent_t e, logic [FHU_REG_ADDR_W-1:0] r);
        return e.valid && e.wb_en && (e.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage to hazard-unit bundle: decoded ID fields in, operand selects and stall out.
// Latency: wires only. sel_a/sel_b are registered inside the unit, and stall is combinational.
// Backpressure: stall is the only backpressure. The ID side holds PC and IF/ID while it is high.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src1_used;
    logic                  id_src2_used;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            sel_a;
    logic [1:0]            sel_b;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    // The pipeline ID stage drives the decoded instruction.
    modport master (
        output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_wb_en, id_mem_read, flush,
        input  sel_a, sel_b, stall, stall_count
    );

    // The hazard unit consumes the decoded instruction and produces the selects.
    modport slave (
        input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_wb_en, id_mem_read, flush,
        output sel_a, sel_b, stall, stall_count
    );
endinterface

// File: rtl/fwd_sel_calc.sv
// Per-source forwarding select and load-use detection against the EX and MEM shadow entries.
// Latency: purely combinational.
// Backpressure: none. load_use feeds the stall of the parent unit.
// Ports: src/used = ID source and its read flag; ex_ent/mem_ent = shadow entries;
//        code = SEL_RF/SEL_EXMEM/SEL_MEMWB; load_use = EX load produces this source.
module fwd_sel_calc
    import fwd_hazard_unit_pkg::*;
(
    input  logic [FHU_REG_ADDR_W-1:0] src,
    input  logic                      used,
    input  shadow_ent_t               ex_ent,
    input  shadow_ent_t               mem_ent,
    output logic [1:0]                code,
    output logic                      load_use
);
    logic ex_hit;
    logic mem_hit;
    logic mem_rd_unused;

    assign ex_hit  = used && produces(ex_ent, src);
    assign mem_hit = used && produces(mem_ent, src);

    // The EX entry is checked first, so the youngest producer wins when both entries match.
    always_comb begin
        code = SEL_RF;
        if (ex_hit) begin
            code = SEL_EXMEM;
        end else if (mem_hit) begin
            code = SEL_MEMWB;
        end
    end

    // A load in EX has no data until MEM. A load already in MEM forwards normally.
    assign load_use = ex_hit && ex_ent.mem_read;

    assign mem_rd_unused = mem_ent.mem_read;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the 16-bit five-stage pipeline.
// Latency: sel_a/sel_b are registered as the instruction enters EX (1 cycle). stall is combinational.
// Backpressure: stall holds PC and IF/ID and injects a bubble. flush overrides stall.
// Ports: clk, rst_n (async active-low); bus = fwd_hazard_unit_if.slave (ID fields, flush in;
//        sel_a, sel_b, stall, stall_count out).
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = FHU_REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);
    shadow_ent_t           ex_q;
    shadow_ent_t           mem_q;
    shadow_ent_t           wb_q;
    shadow_ent_t           id_ent;
    logic [REG_ADDR_W-1:0] src_a;
    logic [REG_ADDR_W-1:0] src_b;
    logic [1:0]            code_a;
    logic [1:0]            code_b;
    logic                  lu_a;
    logic                  lu_b;
    logic                  stall_c;
    logic [1:0]            sel_a_q;
    logic [1:0]            sel_b_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wb_tag_unused;

    assign src_a  = bus.id_src1;
    assign src_b  = bus.id_src2;
    assign id_ent = '{valid: bus.id_valid, dest: bus.id_dest,
                      wb_en: bus.id_wb_en, mem_read: bus.id_mem_read};

    fwd_sel_calc u_sel_a (
        .src      (src_a),
        .used     (bus.id_src1_used),
        .ex_ent   (ex_q),
        .mem_ent  (mem_q),
        .code     (code_a),
        .load_use (lu_a)
    );

    fwd_sel_calc u_sel_b (
        .src      (src_b),
        .used     (bus.id_src2_used),
        .ex_ent   (ex_q),
        .mem_ent  (mem_q),
        .code     (code_b),
        .load_use (lu_b)
    );

    // When the ID instruction is being flushed, stall is suppressed, because the dependent instruction is dead.
    assign stall_c = bus.id_valid && !bus.flush && (lu_a || lu_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= SHADOW_BUBBLE;
            mem_q   <= SHADOW_BUBBLE;
            wb_q    <= SHADOW_BUBBLE;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bus.flush || stall_c) begin
                ex_q    <= SHADOW_BUBBLE;
                sel_a_q <= SEL_RF;
                sel_b_q <= SEL_RF;
            end else begin
                ex_q    <= id_ent;
                sel_a_q <= bus.id_valid ? code_a : SEL_RF;
                sel_b_q <= bus.id_valid ? code_b : SEL_RF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The WB tag is kept so the shadow pipeline mirrors the real one. Nothing forwards from it,
    // because the register file is write-through and ID already sees the written value.
    assign wb_tag_unused = ^wb_q;

    assign bus.sel_a       = sel_a_q;
    assign bus.sel_b       = sel_b_q;
    assign bus.stall       = stall_c;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    localparam int AW      = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit valid;
        int dest;
        bit wb;
        bit load;
    } instr_t;

    typedef struct {
        int sel_a;
        int sel_b;
        int cnt;
    } sel_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int       n_checks = 0;
    int       n_fail   = 0;
    instr_t   inflight[$];   // [0] = instruction now in EX, [1] = instruction now in MEM
    int       model_cnt;
    sel_exp_t sel_q[$];
    bit       stall_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(instr_t e, int r);
        return e.valid && e.wb && (e.dest == r) && (r != 0);
    endfunction

    // The youngest in-flight writer supplies the value: EX maps to code 1 and MEM to code 2.
    function automatic int code_for(int src, bit used);
        if (!used) return 0;
        for (int i = 0; i < 2; i++)
            if (writes(inflight[i], src)) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        instr_t b;
        b = '{valid: 1'b0, dest: 0, wb: 1'b0, load: 1'b0};
        inflight.delete();
        inflight.push_back(b);
        inflight.push_back(b);
        model_cnt = 0;
        sel_q.delete();
        stall_q.delete();
    endtask

    task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input int d, input bit wb, input bit mr, input bit fl);
        bus.id_valid     = v;
        bus.id_src1      = AW'(s1);
        bus.id_src1_used = u1;
        bus.id_src2      = AW'(s2);
        bus.id_src2_used = u2;
        bus.id_dest      = AW'(d);
        bus.id_wb_en     = wb;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
    endtask

    // One ID cycle: apply the inputs, predict stall now and the selects/count after the edge.
    task automatic issue(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input int d, input bit wb, input bit mr, input bit fl, output bit st);
        instr_t   nxt;
        sel_exp_t e;
        bit       lu;
        @(posedge clk);
        #2;
        drive(v, s1, u1, s2, u2, d, wb, mr, fl);
        lu = inflight[0].load && ((u1 && writes(inflight[0], s1)) || (u2 && writes(inflight[0], s2)));
        st = v && !fl && lu;
        stall_q.push_back(st);
        if (fl || st || !v) begin
            nxt = '{valid: 1'b0, dest: 0, wb: 1'b0, load: 1'b0};
            e.sel_a = 0;
            e.sel_b = 0;
        end else begin
            nxt = '{valid: 1'b1, dest: d, wb: wb, load: mr};
            e.sel_a = code_for(s1, u1);
            e.sel_b = code_for(s2, u2);
        end
        if (st && model_cnt < CNT_MAX) model_cnt++;
        e.cnt = model_cnt;
        sel_q.push_back(e);
        inflight.push_front(nxt);
        void'(inflight.pop_back());
    endtask

    task automatic nop();
        bit st;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    // Monitor for the registered outputs, checked just after each edge.
    initial begin
        sel_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sel_q.size() > 0) begin
                e = sel_q.pop_front();
                check("sel_a", int'(bus.sel_a), e.sel_a);
                check("sel_b", int'(bus.sel_b), e.sel_b);
                check("stall_count", int'(bus.stall_count), e.cnt);
            end
        end
    end

    // Monitor for the combinational stall, checked mid-cycle.
    initial begin
        bit s;
        forever begin
            @(negedge clk);
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                check("stall", int'(bus.stall), int'(s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        bit last_st;
        int v, s1, u1, s2, u2, d, wb, mr, fl;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #3;
        check("reset_stall", int'(bus.stall), 0);
        check("reset_sel_a", int'(bus.sel_a), 0);
        check("reset_sel_b", int'(bus.sel_b), 0);
        check("reset_count", int'(bus.stall_count), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // ALU back-to-back: add r1 ; sub r2,r1,r3
        issue(1, 0, 0, 0, 0, 1, 1, 0, 0, st);
        issue(1, 1, 1, 3, 1, 2, 1, 0, 0, st);
        nop(); nop();
        // Distance-2: add r1 ; independent ; reader of r1 in src2
        issue(1, 6, 1, 7, 1, 1, 1, 0, 0, st);
        issue(1, 6, 1, 7, 1, 5, 1, 0, 0, st);
        issue(1, 7, 1, 1, 1, 3, 1, 0, 0, st);
        nop(); nop();
        // Load-use: lw r4 ; add r5,r4,r4 (stalls once, then issues with code 2)
        issue(1, 6, 1, 0, 0, 4, 1, 1, 0, st);
        issue(1, 4, 1, 4, 1, 5, 1, 0, 0, st);
        issue(1, 4, 1, 4, 1, 5, 1, 0, 0, st);
        nop(); nop();
        // R0: write r0 (load) then read r0
        issue(1, 0, 0, 0, 0, 0, 1, 1, 0, st);
        issue(1, 0, 1, 0, 1, 6, 1, 0, 0, st);
        // Double producer of r2, then read r2
        issue(1, 0, 0, 0, 0, 2, 1, 0, 0, st);
        issue(1, 0, 0, 0, 0, 2, 1, 0, 0, st);
        issue(1, 2, 1, 2, 1, 3, 1, 0, 0, st);
        nop(); nop();
        // Flush on the would-be stall cycle
        issue(1, 6, 1, 0, 0, 4, 1, 1, 0, st);
        issue(1, 4, 1, 4, 1, 5, 1, 0, 1, st);
        nop(); nop();
        // Load in MEM: lw r3 ; independent ; read r3 -> code 2, no stall
        issue(1, 6, 1, 0, 0, 3, 1, 1, 0, st);
        issue(1, 6, 1, 6, 1, 7, 1, 0, 0, st);
        issue(1, 3, 1, 5, 1, 1, 1, 0, 0, st);
        nop(); nop();

        // Reset asserted mid-stall
        issue(1, 6, 1, 0, 0, 4, 1, 1, 0, st);
        @(posedge clk);
        #2;
        drive(1, 4, 1, 4, 1, 5, 1, 0, 0);
        #1;
        check("stall_before_reset", int'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", int'(bus.stall), 0);
        check("rst_mid_sel_a", int'(bus.sel_a), 0);
        check("rst_mid_sel_b", int'(bus.sel_b), 0);
        check("rst_mid_count", int'(bus.stall_count), 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nop(); nop(); nop();

        // Randomized traffic. A stalled instruction is usually re-presented, as the real ID stage does.
        last_st = 1'b0;
        v = 0; s1 = 0; u1 = 0; s2 = 0; u2 = 0; d = 0; wb = 0; mr = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(last_st && $urandom_range(0, 4) != 0)) begin
                v  = ($urandom_range(0, 7) != 0) ? 1 : 0;
                s1 = $urandom_range(0, 7);
                s2 = $urandom_range(0, 7);
                u1 = ($urandom_range(0, 3) != 0) ? 1 : 0;
                u2 = ($urandom_range(0, 1) != 0) ? 1 : 0;
                d  = $urandom_range(0, 7);
                mr = ($urandom_range(0, 2) == 0) ? 1 : 0;
                wb = (mr != 0 || $urandom_range(0, 3) != 0) ? 1 : 0;
            end
            fl = ($urandom_range(0, 9) == 0) ? 1 : 0;
            issue(v[0], s1, u1[0], s2, u2[0], d, wb[0], mr[0], fl[0], st);
            last_st = st;
        end
        nop();

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", sel_q.size() + stall_q.size(), 0);
        check("count_saturated", int'(bus.stall_count), model_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
